branch_target_pipe: RTL and testbench
=====================================

BRANCH_TARGET_PIPE -- requirements
Module: branch_target_pipe

Interface
REQ-001 Parameter WIDTH, default 32: address/operand width; SHALL be even and at least 8.
REQ-002 Parameter OFF_W, default 16: offset field width; SHALL satisfy OFF_W+SHIFT < WIDTH.
REQ-003 Parameter SHIFT, default 2: left shift applied to the offset (word alignment).
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  request accepted on a cycle where in_valid=1 and in_ready=1.
REQ-008 in_base  input  WIDTH  base address (PC+4).
REQ-009 in_off  input  OFF_W  signed offset (relative mode) or target index (region mode).
REQ-010 in_mode  input  1  0 = relative branch target, 1 = region jump target.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result on a cycle where out_valid=1 and out_ready=1.
REQ-013 out_target  output  WIDTH  computed target address.
REQ-014 out_ovf  output  1  signed overflow flag; present only when BTU_OVF_DET_EN is defined.

Function
REQ-015 Relative mode SHALL compute in_base + (sign_extend(in_off, WIDTH) << SHIFT), modulo 2^WIDTH.
REQ-016 Region mode SHALL compute {in_base[WIDTH-1:OFF_W+SHIFT], in_off, SHIFT zero bits}; no addition.
REQ-017 The datapath SHALL have two register stages: S1 registers the low WIDTH/2-bit sum, its carry-out and the high operand halves; S2 adds the high halves plus the registered carry.
REQ-018 Latency SHALL be exactly 2 cycles from acceptance to out_valid=1 when out_ready is held at 1.
REQ-019 Stage enables: en2 = !s2_valid | out_ready; en1 = !s1_valid | en2; in_ready SHALL equal en1, combinationally.
REQ-020 Throughput SHALL be one result per cycle while out_ready=1; no bubbles are inserted.
REQ-021 While out_valid=1 and out_ready=0, out_target (and out_ovf) SHALL hold stable, and S1 SHALL hold if occupied.
REQ-022 Acceptance while S2 drains SHALL be lossless: a simultaneous input accept and output retire in the same cycle moves both stages.
REQ-023 Results SHALL emerge in acceptance order; no request may be dropped or duplicated.
REQ-024 Wrap-around: relative-mode sums exceeding WIDTH bits SHALL wrap with no error indication other than out_ovf.
REQ-025 in_mode SHALL be captured with the request; it SHALL NOT affect in-flight entries.

Reset
REQ-026 Assertion of rst_n=0 SHALL immediately clear s1_valid, s2_valid, and therefore out_valid; out_target and out_ovf SHALL be 0.
REQ-027 Reset mid-operation SHALL discard all in-flight requests; none SHALL appear after release.
REQ-028 in_ready SHALL be 1 during reset and on the first cycle after release.

Configuration
REQ-029 Macro BTU_OVF_DET_EN defined: out_ovf SHALL be 1 when, in relative mode, the signs of in_base and the shifted offset are equal and the sign of out_target differs; it SHALL be 0 in region mode; it SHALL be pipelined alongside out_target.
REQ-030 Macro BTU_OVF_DET_EN undefined: out_ovf port and all overflow logic SHALL be absent; all other behaviour is identical.

Verification (defaults WIDTH=32, OFF_W=16, SHIFT=2)
REQ-031 Relative forward: base 0x00400004, off 0x0003, mode 0, out_ready=1 -> out_target 0x00400010 exactly 2 cycles after accept.
REQ-032 Relative backward and carry crossing the halves: base 0x00010004, off 0xFFFE -> 0x0000FFFC; base 0x00400004, off 0xFFFF -> 0x00400000.
REQ-033 Region mode: base 0x40000004, off 0x1234, mode 1 -> 0x400048D0, out_ovf=0.
REQ-034 Backpressure: 4 back-to-back requests with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, out_target stable, then all 4 results emerge in order with no loss once out_ready=1.
REQ-035 Reset mid-stream: rst_n pulled low with both stages full -> out_valid=0 asynchronously; after release no stale result appears.
REQ-036 Overflow (BTU_OVF_DET_EN defined): base 0x7FFFFFFC, off 0x0001, mode 0 -> 0x80000000, out_ovf=1; same input with the macro undefined -> 0x80000000, port absent.

Source files
------------

// File: rtl/branch_target_pipe.sv
// branch_target_pipe
//   Two-stage branch/jump target address pipeline with valid/ready handshake
//   on both sides.
//
//   Relative mode (in_mode=0):
//      target = in_base + (sign_extend(in_off) << SHIFT), wrapping modulo 2^WIDTH.
//   Region mode (in_mode=1):
//      target = {in_base[WIDTH-1:OFF_W+SHIFT], in_off, SHIFT zero bits}.
//
//   The addition is split into halves. Stage 1 registers the low-half sum,
//   its carry-out and both high operand halves. Stage 2 adds the high halves
//   together with the registered carry.
//
//   Optional feature, enabled by defining the macro BTU_OVF_DET_EN:
//      out_ovf is the signed-overflow flag for relative mode. It is always 0
//      in region mode, and it travels through the pipe alongside out_target.
//      With the macro undefined, the port and all overflow logic are absent.
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    request present
//   in_ready    request accepted when in_valid && in_ready
//   in_base     base address (PC+4), WIDTH bits
//   in_off      signed offset (relative mode) or target index (region mode)
//   in_mode     0 = relative, 1 = region
//   out_valid   result present
//   out_ready   consumer accepts the result when out_valid && out_ready
//   out_target  computed target address
//   out_ovf     signed overflow flag (only with BTU_OVF_DET_EN)
module branch_target_pipe #(
    parameter int WIDTH = 32,
    parameter int OFF_W = 16,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_base,
    input  logic [OFF_W-1:0] in_off,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_target
`ifdef BTU_OVF_DET_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int HW = WIDTH / 2;
    // Set on the base bits that region mode keeps unchanged.
    localparam logic [WIDTH-1:0] HI_MASK =
        ~((WIDTH'(1) << (OFF_W + SHIFT)) - WIDTH'(1));

    logic             en1, en2;
    logic [WIDTH-1:0] off_ext, rel_b, region, op_a, op_b;
    logic [HW:0]      lo_sum;
    logic [HW-1:0]    hi_sum;

    logic             s1_valid;
    logic [HW-1:0]    s1_lo;
    logic             s1_carry;
    logic [HW-1:0]    s1_ahi, s1_bhi;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_target;

    assign en2      = !s2_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign in_ready = en1;

    // Region mode goes through the same adder with a zero second operand.
    // This keeps a single datapath, and the shared pipeline keeps results
    // in acceptance order.
    always_comb begin
        off_ext = {{(WIDTH - OFF_W){in_off[OFF_W-1]}}, in_off};
        rel_b   = off_ext << SHIFT;
        region  = (in_base & HI_MASK) | (WIDTH'(in_off) << SHIFT);
        op_a    = in_mode ? region : in_base;
        op_b    = in_mode ? '0 : rel_b;
        lo_sum  = {1'b0, op_a[HW-1:0]} + {1'b0, op_b[HW-1:0]};
        hi_sum  = s1_ahi + s1_bhi + HW'(s1_carry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_carry <= 1'b0;
            s1_ahi   <= '0;
            s1_bhi   <= '0;
        end else if (en1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo    <= lo_sum[HW-1:0];
                s1_carry <= lo_sum[HW];
                s1_ahi   <= op_a[WIDTH-1:HW];
                s1_bhi   <= op_b[WIDTH-1:HW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_target <= '0;
        end else if (en2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_target <= {hi_sum, s1_lo};
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_target = s2_target;

`ifdef BTU_OVF_DET_EN
    logic s1_rel;
    logic s2_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rel <= 1'b0;
        end else if (en1 && in_valid) begin
            s1_rel <= !in_mode;
        end
    end

    // Overflow: both operands have the same sign, and the sum's sign differs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_ovf <= 1'b0;
        end else if (en2 && s1_valid) begin
            s2_ovf <= s1_rel && (s1_ahi[HW-1] == s1_bhi[HW-1])
                      && (hi_sum[HW-1] != s1_ahi[HW-1]);
        end
    end

    assign out_ovf = s2_ovf;
`endif

endmodule

// File: tb/tb_branch_target_pipe.sv
module tb_branch_target_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_base;
    logic [15:0] in_off;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_target;
`ifdef BTU_OVF_DET_EN
    logic        out_ovf;
`endif

    int tests;
    int fails;

    branch_target_pipe #(.WIDTH(32), .OFF_W(16), .SHIFT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_base    (in_base),
        .in_off     (in_off),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_target (out_target)
`ifdef BTU_OVF_DET_EN
        ,
        .out_ovf    (out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] b, input logic [15:0] o, input logic m);
        in_valid = 1'b1;
        in_base  = b;
        in_off   = o;
        in_mode  = m;
    endtask

    logic [31:0] bp_base [4];
    logic [15:0] bp_off  [4];
    logic [31:0] bp_exp  [4];
    int          nidx;
    int          ridx;
    logic        acc;
    logic        stale;

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_base   = '0;
        in_off    = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_target", out_target, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Relative forward: 0x00400004 + (3 << 2).
        drive(32'h0040_0004, 16'h0003, 1'b0);
        step();
        in_valid = 1'b0;
        check("fwd_lat1_valid", out_valid, 0);
        step();
        check("fwd_lat2_valid", out_valid, 1);
        check("fwd_target", out_target, 32'h0040_0010);
`ifdef BTU_OVF_DET_EN
        check("fwd_ovf", out_ovf, 0);
`endif
        step();
        check("fwd_drained", out_valid, 0);

        // Back-to-back: carry across halves, backward offset, then region mode.
        drive(32'h0001_0004, 16'hFFFE, 1'b0);
        step();
        drive(32'h0040_0004, 16'hFFFF, 1'b0);
        step();
        check("b2b_a_valid", out_valid, 1);
        check("b2b_a_target", out_target, 32'h0000_FFFC);
        drive(32'h4000_0004, 16'h1234, 1'b1);
        step();
        in_valid = 1'b0;
        check("b2b_b_valid", out_valid, 1);
        check("b2b_b_target", out_target, 32'h0040_0000);
        step();
        check("region_valid", out_valid, 1);
        check("region_target", out_target, 32'h4000_48D0);
`ifdef BTU_OVF_DET_EN
        check("region_ovf", out_ovf, 0);
`endif
        step();
        check("b2b_drained", out_valid, 0);

        // Backpressure: four requests while out_ready=0.
        for (int i = 0; i < 4; i++) begin
            bp_base[i] = 32'h1000_0000 + 32'(i) * 32'h100;
            bp_off[i]  = 16'(i + 1);
            bp_exp[i]  = bp_base[i] + 32'(4 * (i + 1));
        end
        out_ready = 1'b0;
        drive(bp_base[0], bp_off[0], 1'b0);
        check("bp_ready0", in_ready, 1);
        step();
        drive(bp_base[1], bp_off[1], 1'b0);
        check("bp_ready1", in_ready, 1);
        step();
        drive(bp_base[2], bp_off[2], 1'b0);
        check("bp_ready_drop", in_ready, 0);
        step();
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_target1", out_target, bp_exp[0]);
        step();
        check("bp_hold_target2", out_target, bp_exp[0]);
        check("bp_hold_ready", in_ready, 0);
        step();
        check("bp_hold_target3", out_target, bp_exp[0]);
        out_ready = 1'b1;
        #1;
        check("bp_ready_release", in_ready, 1);
        nidx = 2;
        ridx = 0;
        for (int cyc = 0; cyc < 20 && ridx < 4; cyc++) begin
            if (out_valid) begin
                check("bp_order", out_target, bp_exp[ridx]);
                ridx++;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                nidx++;
                if (nidx < 4) drive(bp_base[nidx], bp_off[nidx], 1'b0);
                else in_valid = 1'b0;
            end
        end
        check("bp_all_results", ridx, 4);
        check("bp_no_extra", out_valid, 0);

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        drive(32'h2000_0000, 16'h0001, 1'b0);
        step();
        drive(32'h2000_0100, 16'h0002, 1'b0);
        step();
        in_valid = 1'b0;
        check("mid_full_valid", out_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_target", out_target, 0);
        check("mid_rst_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid) stale = 1'b1;
        end
        check("mid_no_stale", stale, 0);

        // Signed overflow: 0x7FFFFFFC + 4 wraps to 0x80000000.
        drive(32'h7FFF_FFFC, 16'h0001, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        check("ovf_valid", out_valid, 1);
        check("ovf_target", out_target, 32'h8000_0000);
`ifdef BTU_OVF_DET_EN
        check("ovf_flag", out_ovf, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog: if the run exceeds its time limit, report it and stop.
    initial begin
        #20000;
        $display("FAIL watchdog: timeout observed, finish required");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
